predictor_port_scheduler: RTL and testbench
===========================================

Name: predictor_port_scheduler

Overview:
Controller that owns the single-ported 2-bit-counter branch history table (BHT) and shares its one access port between fetch-side lookups (icache) and commit-side updates (Reorder Buffer).
- Sequences a post-reset table initialisation walk.
- Buffers ROB updates in a small FIFO.
- Performs each update as a two-cycle read-modify-write with a saturating counter.
- Returns the jump prediction one cycle after a lookup is accepted.

Parameters:
IDX_WIDTH, 12, table index width; table holds 2**IDX_WIDTH entries; index = addr[IDX_WIDTH+1:2]
UPD_DEPTH, 4, update FIFO depth; power of two, >= 2

Ports:
clockIn  input  1  clock
resetIn  input  1  synchronous active-high reset
lookupValid  input  1  fetch lookup request (icache)
lookupAddr  input  32  instruction address to predict
lookupReady  output  1  lookup accepted this cycle when lookupValid && lookupReady
predValid  output  1  prediction valid (one cycle after acceptance)
predJump  output  1  predicted taken
updateValid  input  1  ROB update request
updateInstr  input  32  address of committed branch
updateTaken  input  1  resolved outcome
updateReady  output  1  update enqueued when updateValid && updateReady
initDone  output  1  table initialisation complete
tableEn  output  1  table port enable
tableWe  output  1  table write enable
tableAddr  output  IDX_WIDTH  table index
tableWdata  output  2  write data
tableRdata  input  2  read data; valid the cycle after a read (tableEn && !tableWe)

Behaviour:
- Reset values:
  - state = INIT, init counter = 0, FIFO empty.
  - predValid = 0, initDone = 0, lookupReady = 0, updateReady = 0.
  - tableEn = 0, tableWe = 0.
- Reset asserted mid-operation (including mid-RMW):
  - Pending FIFO contents are discarded.
  - Any in-flight prediction is dropped.
  - Initialisation restarts from index 0.
- INIT state:
  - Each cycle drives tableEn = 1, tableWe = 1, tableAddr = counter, tableWdata = 2'b01, then increments the counter.
  - After writing index 2**IDX_WIDTH-1 the next state is IDLE and initDone = 1; initDone stays 1 until reset.
  - Init therefore takes 2**IDX_WIDTH cycles.
  - lookupReady = 0 and updateReady = 0 throughout INIT.
- updateReady = initDone && (count < UPD_DEPTH), from the registered count.
  - At full, updateReady = 0 even in a cycle where a pop occurs.
- lookupReady = (state == IDLE) && !fifoFull (combinational).
- IDLE arbitration, priority order:
  1. FIFO full -> go to UPD_RD (anti-starvation).
  2. lookupValid -> read lookup index; stay IDLE.
  3. FIFO non-empty -> go to UPD_RD.
  4. Otherwise tableEn = 0.
- Accepted lookup:
  - tableEn = 1, tableWe = 0, tableAddr = lookupAddr[IDX_WIDTH+1:2].
  - Next cycle predValid = 1, predJump = tableRdata[1].
  - predJump = 0 whenever predValid = 0.
  - Back-to-back lookups give one prediction per cycle.
- UPD_RD: read head entry index (tableWe = 0); next state UPD_WR.
- UPD_WR:
  - tableWe = 1, same address.
  - tableWdata = taken ? sat_inc(tableRdata) : sat_dec(tableRdata); 2'b11 + taken = 2'b11, 2'b00 - not taken = 2'b00.
  - Pop FIFO; next state IDLE.
- An update costs 2 port cycles; lookups stall (lookupReady = 0) in UPD_RD and UPD_WR.
- Simultaneous enqueue and pop: allowed when not full; count is unchanged.
- An enqueue in the same cycle as IDLE arbitration is not visible until the next cycle.
- FIFO pointers wrap modulo UPD_DEPTH; updates apply in ROB order.
- No bypass: a lookup racing a queued update sees the pre-update counter.

Optional Feature:
PREDICTOR_SCHED_STATS_EN
- Defined:
  - Adds 32-bit outputs lookupStallCount and updateStallCount.
  - lookupStallCount increments each cycle with lookupValid && !lookupReady after initDone.
  - updateStallCount increments each cycle with updateValid && !updateReady after initDone.
  - Both counters wrap, and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package predictor_pkg:
  - Counter width 2 and init value 2'b01.
  - State encoding INIT/IDLE/UPD_RD/UPD_WR.
  - Index-extraction and saturating-update functions.
- One sub-module: predictor_update_fifo.
  - Parameterised depth; entry = {index, taken}.
  - Provides push/pop/full/empty/count.

Test Plan:
- Reset then idle, IDX_WIDTH = 4 -> 16 consecutive writes of 2'b01 to addresses 0..15, then initDone = 1.
- Lookup 0x00000010 after init -> tableAddr = 4, next cycle predValid = 1, predJump = 0.
- Three taken updates to 0x10, then lookup -> counter sequence 01 -> 10 -> 11 -> 11; predJump = 1; a fourth taken update leaves 2'b11.
- Continuous lookupValid plus 4 back-to-back updates -> FIFO fills, updateReady = 0, lookupReady drops, all 4 RMWs complete (8 port cycles), then lookups resume.
- resetIn pulsed during UPD_WR with 2 entries queued -> no write that cycle, FIFO empty, INIT restarts at index 0.
- STATS build: hold lookupValid for 5 stall cycles -> lookupStallCount = 5.

Source files
------------

// File: rtl/predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : predictor_pkg
// Brief   : Shared types, constants and helpers for the branch predictor
//           table scheduler (2-bit counters, scheduler states).
// Rev     : 1.0  initial release
// ============================================================================
package predictor_pkg;

    localparam int               CTR_W    = 2;
    localparam logic [CTR_W-1:0] CTR_INIT = 2'b01;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } state_t;

    // Word index of an instruction address; callers truncate to the table width.
    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    function automatic logic [CTR_W-1:0] sat_update(input logic [CTR_W-1:0] ctr,
                                                    input logic             taken);
        if (taken)
            return (ctr == '1) ? ctr : ctr + CTR_W'(1);
        else
            return (ctr == '0) ? ctr : ctr - CTR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/predictor_update_fifo.sv
`default_nettype none
// ============================================================================
// Module  : predictor_update_fifo
// Brief   : Small power-of-two FIFO holding pending {index, taken} updates.
// Rev     : 1.0  initial release
// ============================================================================
module predictor_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == (PTR_W+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/predictor_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : predictor_port_scheduler
// Brief   : Shares the single BHT port between fetch lookups and queued ROB
//           read-modify-write updates; walks the table to 2'b01 after reset.
//           Define PREDICTOR_SCHED_STATS_EN to add stall counters.
// Rev     : 1.0  initial release
// ============================================================================
module predictor_port_scheduler
    import predictor_pkg::*;
#(
    parameter int IDX_WIDTH = 12,
    parameter int UPD_DEPTH = 4
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 lookupValid,
    input  logic [31:0]          lookupAddr,
    output logic                 lookupReady,
    output logic                 predValid,
    output logic                 predJump,
    input  logic                 updateValid,
    input  logic [31:0]          updateInstr,
    input  logic                 updateTaken,
    output logic                 updateReady,
    output logic                 initDone,
    output logic                 tableEn,
    output logic                 tableWe,
    output logic [IDX_WIDTH-1:0] tableAddr,
    output logic [CTR_W-1:0]     tableWdata,
    input  logic [CTR_W-1:0]     tableRdata
`ifdef PREDICTOR_SCHED_STATS_EN
    ,
    output logic [31:0]          lookupStallCount,
    output logic [31:0]          updateStallCount
`endif
);

    localparam int CNT_W = $clog2(UPD_DEPTH) + 1;
    localparam int ENT_W = IDX_WIDTH + 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_WIDTH-1:0] r_init_idx;
    logic [IDX_WIDTH-1:0] w_init_idx_nxt;
    logic                 r_init_done;
    logic                 w_init_done_nxt;
    logic                 r_pred_valid;
    logic                 w_lookup_fire;
    logic                 w_push;
    logic                 w_pop;
    logic [IDX_WIDTH-1:0] w_lookup_idx;
    logic [IDX_WIDTH-1:0] w_update_idx;
    logic [ENT_W-1:0]     w_head;
    logic [IDX_WIDTH-1:0] w_head_idx;
    logic                 w_head_taken;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [CNT_W-1:0]     w_fifo_count;

    assign w_lookup_idx = IDX_WIDTH'(word_index(lookupAddr));
    assign w_update_idx = IDX_WIDTH'(word_index(updateInstr));
    assign w_head_idx   = w_head[ENT_W-1:1];
    assign w_head_taken = w_head[0];

    // Ready uses the registered count, so a same-cycle pop never frees a slot.
    assign updateReady = r_init_done && !resetIn && (w_fifo_count < CNT_W'(UPD_DEPTH));
    assign w_push      = updateValid && updateReady;

    predictor_update_fifo #(
        .DEPTH (UPD_DEPTH),
        .WIDTH (ENT_W)
    ) u_update_fifo (
        .clk       (clockIn),
        .rst       (resetIn),
        .push      (w_push),
        .push_data ({w_update_idx, updateTaken}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            r_state      <= ST_INIT;
            r_init_idx   <= '0;
            r_init_done  <= 1'b0;
            r_pred_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_init_idx   <= w_init_idx_nxt;
            r_init_done  <= w_init_done_nxt;
            r_pred_valid <= w_lookup_fire;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_init_idx_nxt  = r_init_idx;
        w_init_done_nxt = r_init_done;
        w_lookup_fire   = 1'b0;
        w_pop           = 1'b0;
        lookupReady     = 1'b0;
        tableEn         = 1'b0;
        tableWe         = 1'b0;
        tableAddr       = '0;
        tableWdata      = '0;

        case (r_state)
            ST_INIT: begin
                tableEn        = 1'b1;
                tableWe        = 1'b1;
                tableAddr      = r_init_idx;
                tableWdata     = CTR_INIT;
                w_init_idx_nxt = r_init_idx + IDX_WIDTH'(1);
                if (r_init_idx == '1) begin
                    w_state_nxt     = ST_IDLE;
                    w_init_done_nxt = 1'b1;
                end
            end
            ST_IDLE: begin
                lookupReady = !w_fifo_full;
                // A full queue outranks fetch so updates cannot starve.
                if (w_fifo_full) begin
                    w_state_nxt = ST_UPD_RD;
                end else if (lookupValid) begin
                    tableEn       = 1'b1;
                    tableAddr     = w_lookup_idx;
                    w_lookup_fire = 1'b1;
                end else if (!w_fifo_empty) begin
                    w_state_nxt = ST_UPD_RD;
                end
            end
            ST_UPD_RD: begin
                tableEn     = 1'b1;
                tableAddr   = w_head_idx;
                w_state_nxt = ST_UPD_WR;
            end
            ST_UPD_WR: begin
                tableEn     = 1'b1;
                tableWe     = 1'b1;
                tableAddr   = w_head_idx;
                tableWdata  = sat_update(tableRdata, w_head_taken);
                w_pop       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_INIT;
        endcase

        // Suppress all port activity while reset is held, even mid-RMW.
        if (resetIn) begin
            tableEn       = 1'b0;
            tableWe       = 1'b0;
            lookupReady   = 1'b0;
            w_lookup_fire = 1'b0;
            w_pop         = 1'b0;
        end
    end

    assign initDone  = r_init_done;
    assign predValid = r_pred_valid;
    assign predJump  = r_pred_valid && tableRdata[1];

`ifdef PREDICTOR_SCHED_STATS_EN
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            lookupStallCount <= '0;
            updateStallCount <= '0;
        end else begin
            if (r_init_done && lookupValid && !lookupReady)
                lookupStallCount <= lookupStallCount + 32'd1;
            if (r_init_done && updateValid && !updateReady)
                updateStallCount <= updateStallCount + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_predictor_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_predictor_port_scheduler
// Brief   : Self-checking bench: directed vector table, hand-written corner
//           sequences and randomized traffic against a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_predictor_port_scheduler;

    localparam int IW    = 4;
    localparam int DEPTH = 4;
    localparam int NENT  = 1 << IW;

    logic          clockIn     = 1'b0;
    logic          resetIn     = 1'b1;
    logic          lookupValid = 1'b0;
    logic [31:0]   lookupAddr  = '0;
    logic          updateValid = 1'b0;
    logic [31:0]   updateInstr = '0;
    logic          updateTaken = 1'b0;
    logic          lookupReady, predValid, predJump, updateReady, initDone;
    logic          tableEn, tableWe;
    logic [IW-1:0] tableAddr;
    logic [1:0]    tableWdata;
    logic [1:0]    tableRdata = 2'b00;
`ifdef PREDICTOR_SCHED_STATS_EN
    logic [31:0]   lookupStallCount, updateStallCount;
`endif

    predictor_port_scheduler #(.IDX_WIDTH(IW), .UPD_DEPTH(DEPTH)) dut (
        .clockIn     (clockIn),
        .resetIn     (resetIn),
        .lookupValid (lookupValid),
        .lookupAddr  (lookupAddr),
        .lookupReady (lookupReady),
        .predValid   (predValid),
        .predJump    (predJump),
        .updateValid (updateValid),
        .updateInstr (updateInstr),
        .updateTaken (updateTaken),
        .updateReady (updateReady),
        .initDone    (initDone),
        .tableEn     (tableEn),
        .tableWe     (tableWe),
        .tableAddr   (tableAddr),
        .tableWdata  (tableWdata),
        .tableRdata  (tableRdata)
`ifdef PREDICTOR_SCHED_STATS_EN
        ,
        .lookupStallCount (lookupStallCount),
        .updateStallCount (updateStallCount)
`endif
    );

    always #5 clockIn = ~clockIn;

    // Single-port table memory with one-cycle read latency.
    logic [1:0] ram [NENT];
    always @(posedge clockIn) begin
        if (tableEn) begin
            if (tableWe) ram[tableAddr] <= tableWdata;
            else         tableRdata     <= ram[tableAddr];
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [IW-1:0] idx_of(input logic [31:0] a);
        return a[IW+1:2];
    endfunction

    function automatic logic [1:0] bump(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // Reference model: counter per entry plus the ordered list of accepted updates.
    typedef struct packed { logic [IW-1:0] idx; logic taken; } upd_t;
    logic [1:0] ref_ctr [NENT];
    upd_t       q[$];
    bit         m_en = 0, pend = 0, pend_exp = 0;
    bit         f_lacc, f_uacc, f_wr, f_pv, f_pj, f_en, f_we, f_lr, f_ur;
    logic [IW-1:0] f_addr;
    logic [1:0]    f_wdata;

    task automatic monitor();
        upd_t       h;
        logic [1:0] e;
        f_lacc = lookupValid && lookupReady;
        f_uacc = updateValid && updateReady;
        f_wr   = tableEn && tableWe;
        f_en = tableEn; f_we = tableWe; f_pv = predValid; f_pj = predJump;
        f_lr = lookupReady; f_ur = updateReady; f_addr = tableAddr; f_wdata = tableWdata;
        if (!m_en) return;
        if (pend) begin
            chk("pred_valid", predValid, 1);
            chk("pred_jump", predJump, pend_exp);
        end else begin
            chk("pred_quiet", {predValid, predJump}, 0);
        end
        chk("update_ready", updateReady, q.size() < DEPTH);
        if (q.size() == DEPTH) chk("lookup_ready_full", lookupReady, 0);
        pend = f_lacc;
        if (f_lacc) begin
            chk("lookup_port", {tableEn, tableWe, tableAddr}, {1'b1, 1'b0, idx_of(lookupAddr)});
            pend_exp = ref_ctr[idx_of(lookupAddr)][1];
        end
        if (f_wr) begin
            chk("write_has_pending", q.size() > 0, 1);
            if (q.size() > 0) begin
                h = q.pop_front();
                e = bump(ref_ctr[h.idx], h.taken);
                chk("write_addr", tableAddr, h.idx);
                chk("write_data", tableWdata, e);
                ref_ctr[h.idx] = e;
            end
        end
        if (f_uacc) q.push_back('{idx: idx_of(updateInstr), taken: updateTaken});
    endtask

    task automatic cycle();
        @(negedge clockIn);
        monitor();
        @(posedge clockIn);
        #1;
    endtask

    task automatic do_init();
        m_en = 0;
        for (int i = 0; i < NENT; i++) begin
            @(negedge clockIn);
            chk("init_write", {tableEn, tableWe, tableAddr, tableWdata}, {2'b11, IW'(i), 2'b01});
            chk("init_ready", {initDone, lookupReady, updateReady}, 0);
            @(posedge clockIn);
            #1;
            if (i == NENT - 1) begin
                lookupValid = 0;
                updateValid = 0;
            end
        end
        @(negedge clockIn);
        chk("init_done", {initDone, tableEn}, 2'b10);
        @(posedge clockIn);
        #1;
        for (int i = 0; i < NENT; i++) ref_ctr[i] = 2'b01;
        q.delete();
        pend = 0;
        m_en = 1;
    endtask

    typedef struct {
        bit            is_upd;
        logic [31:0]   addr;
        bit            taken;
        logic [IW-1:0] exp_idx;
        logic [1:0]    exp_val;
    } vec_t;
    vec_t vecs[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc, wr, found;
        int writes, ports;
        bit lv_pat [11];
        bit uv_pat [11];

        vecs[0]  = '{0, 32'h0000_0010, 0, 4'd4,  2'd0};
        vecs[1]  = '{1, 32'h0000_0010, 1, 4'd4,  2'b10};
        vecs[2]  = '{1, 32'h0000_0010, 1, 4'd4,  2'b11};
        vecs[3]  = '{1, 32'h0000_0010, 1, 4'd4,  2'b11};
        vecs[4]  = '{0, 32'h0000_0010, 0, 4'd4,  2'd1};
        vecs[5]  = '{1, 32'h0000_0010, 1, 4'd4,  2'b11};
        vecs[6]  = '{1, 32'h0000_0010, 0, 4'd4,  2'b10};
        vecs[7]  = '{0, 32'h0000_0010, 0, 4'd4,  2'd1};
        vecs[8]  = '{1, 32'h0000_0010, 0, 4'd4,  2'b01};
        vecs[9]  = '{1, 32'h0000_0010, 0, 4'd4,  2'b00};
        vecs[10] = '{1, 32'h0000_0010, 0, 4'd4,  2'b00};
        vecs[11] = '{0, 32'h0000_0010, 0, 4'd4,  2'd0};
        vecs[12] = '{0, 32'hFFFF_FFFC, 0, 4'd15, 2'd0};
        vecs[13] = '{1, 32'h0000_0044, 1, 4'd1,  2'b10};
        vecs[14] = '{0, 32'h1234_5684, 0, 4'd1,  2'd1};

        // Reset with requests pending: everything must stay quiet.
        lookupValid = 1; updateValid = 1;
        @(posedge clockIn); #1;
        @(negedge clockIn);
        chk("reset_outputs", {tableEn, tableWe, predValid, predJump, initDone, lookupReady, updateReady}, 0);
        @(posedge clockIn); #1;
        resetIn = 0;
        do_init();

        for (int v = 0; v < 15; v++) begin
            acc = 0;
            if (vecs[v].is_upd) begin
                updateValid = 1; updateInstr = vecs[v].addr; updateTaken = vecs[v].taken;
                for (int k = 0; k < 8 && !acc; k++) begin cycle(); acc = f_uacc; end
                updateValid = 0;
                chk("vec_update_accept", acc, 1);
                wr = 0;
                for (int k = 0; k < 8 && !wr; k++) begin cycle(); wr = f_wr; end
                chk("vec_write_seen", wr, 1);
                chk("vec_write", {f_addr, f_wdata}, {vecs[v].exp_idx, vecs[v].exp_val});
            end else begin
                lookupValid = 1; lookupAddr = vecs[v].addr;
                for (int k = 0; k < 8 && !acc; k++) begin cycle(); acc = f_lacc; end
                lookupValid = 0;
                chk("vec_lookup_accept", acc, 1);
                chk("vec_lookup_addr", f_addr, vecs[v].exp_idx);
                cycle();
                chk("vec_pred", {f_pv, f_pj}, {1'b1, vecs[v].exp_val[0]});
            end
        end

        // Fill the queue under continuous lookups, then drain with fetch idle.
        for (int k = 0; k < DEPTH; k++) begin
            lookupValid = 1; lookupAddr = 32'h20;
            updateValid = 1; updateInstr = 32'h30 + 32'(4 * k); updateTaken = k[0];
            cycle();
            chk("fill_accept", f_uacc, 1);
        end
        updateValid = 0;
        cycle();
        chk("full_ready", {f_lr, f_ur}, 0);
        lookupValid = 0;
        writes = 0; ports = 0;
        for (int k = 0; k < 14; k++) begin
            cycle();
            writes += int'(f_wr);
            ports  += int'(f_en);
        end
        chk("rmw_writes", writes, 4);
        chk("rmw_port_cycles", ports, 8);
        lookupValid = 1;
        cycle();
        chk("lookup_resume", f_lacc, 1);
        lookupValid = 0;
        cycle();

        for (int c = 0; c < 3000; c++) begin
            lookupValid = ($urandom % 100) < 55;
            lookupAddr  = $urandom;
            updateValid = ($urandom % 100) < 45;
            updateInstr = $urandom;
            updateTaken = $urandom % 2;
            cycle();
        end
        lookupValid = 0; updateValid = 0;
        for (int k = 0; k < 40 && q.size() != 0; k++) cycle();
        chk("drain_empty", q.size(), 0);
        cycle(); cycle();
        for (int i = 0; i < NENT; i++) chk("table_contents", ram[i], ref_ctr[i]);

        // Reset asserted during UPD_WR with two updates queued.
        lookupValid = 1; lookupAddr = 32'h8;
        updateValid = 1; updateInstr = 32'h50; updateTaken = 1;
        cycle();
        updateInstr = 32'h54;
        cycle();
        updateValid = 0; lookupValid = 0;
        found = 0;
        for (int k = 0; k < 6 && !found; k++) begin cycle(); found = f_en && !f_we; end
        chk("reached_upd_rd", found, 1);
        m_en = 0;
        resetIn = 1; lookupValid = 1; updateValid = 1;
        @(negedge clockIn);
        chk("reset_in_wr_port", {tableEn, tableWe, lookupReady, updateReady}, 0);
        @(posedge clockIn); #1;
        resetIn = 0;
        do_init();
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("fifo_flushed", f_en, 0);
        end

        // Deterministic stall pattern: five lookup stalls, two update stalls.
        lv_pat = '{1,1,1,1,1,1,1,1,1,1,0};
        uv_pat = '{1,1,1,1,0,0,0,1,1,1,0};
        for (int c = 0; c < 11; c++) begin
            lookupValid = lv_pat[c]; lookupAddr = 32'h3C;
            updateValid = uv_pat[c]; updateInstr = 32'h40 + 32'(4 * c); updateTaken = 1;
            cycle();
        end
        lookupValid = 0; updateValid = 0;
        for (int k = 0; k < 20 && q.size() != 0; k++) cycle();
        chk("stall_drain_empty", q.size(), 0);
`ifdef PREDICTOR_SCHED_STATS_EN
        chk("lookup_stall_count", lookupStallCount, 5);
        chk("update_stall_count", updateStallCount, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
